// File: rtl/jtkicker_pal_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtkicker_pal_pkg
// Description : Shared types, bank codes and helpers for the palette loader.
// Revision    : 1.0 - initial release
// ============================================================================
package jtkicker_pal_pkg;

  // Loader sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Colour PROM selected by the two top download-address bits
  localparam logic [1:0] BANK_R   = 2'd0;
  localparam logic [1:0] BANK_G   = 2'd1;
  localparam logic [1:0] BANK_B   = 2'd2;
  localparam logic [1:0] BANK_INV = 2'd3;

  // Number of PROM writes that make up a complete palette download
  function automatic int unsigned prom_total(input int unsigned aw);
    return 3 * (32'd1 << aw);
  endfunction

  // One-hot {B,G,R} write enable for a bank; the invalid bank enables nothing
  function automatic logic [2:0] bank_onehot(input logic [1:0] bank);
    case (bank)
      BANK_R:  return 3'b001;
      BANK_G:  return 3'b010;
      BANK_B:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtkicker_pal_latch.sv
`default_nettype none
// ============================================================================
// Module      : jtkicker_pal_latch
// Description : CPU palette-bank shadow register with optional transfer to
//               the colour mixer at the start of vertical blank.
// Revision    : 1.0 - initial release
// ============================================================================
module jtkicker_pal_latch #(
  parameter int SYNC_PAL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cpu_pal_sel_i,
  input  logic       cpu_pal_we_i,
  input  logic       LVBL_i,
  output logic [3:0] pal_sel_o
);

  if (SYNC_PAL != 0) begin : g_sync
    logic [3:0] shadow_q;
    logic       lvbl_q;
    logic [3:0] pal_q;

    // Shadow the CPU value and hand it over on the LVBL 1->0 transition; a CPU
    // write on that same edge lands in the shadow and waits for the next frame
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_q <= 4'd0;
        lvbl_q   <= 1'b0;
        pal_q    <= 4'd0;
      end else begin
        lvbl_q <= LVBL_i;
        if (cpu_pal_we_i) shadow_q <= cpu_pal_sel_i;
        if (lvbl_q && !LVBL_i) pal_q <= shadow_q;
      end
    end

    assign pal_sel_o = pal_q;
  end else begin : g_async
    logic [3:0] pal_q;
    logic       w_unused_lvbl;

    assign w_unused_lvbl = LVBL_i;

    // Without frame sync the CPU value goes straight through one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pal_q <= 4'd0;
      else if (cpu_pal_we_i) pal_q <= cpu_pal_sel_i;
    end

    assign pal_sel_o = pal_q;
  end

endmodule
`default_nettype wire

// File: rtl/jtkicker_pal_loader.sv
`default_nettype none
// ============================================================================
// Module      : jtkicker_pal_loader
// Description : Routes ROM-download bytes into the R/G/B colour PROMs, counts
//               the writes of a palette download and owns the palette bank.
// Revision    : 1.0 - initial release
// ============================================================================
module jtkicker_pal_loader
  import jtkicker_pal_pkg::*;
#(
  parameter int WR_CYC   = 2,
  parameter int PROM_AW  = 8,
  parameter int SYNC_PAL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dl_start_i,
  input  logic               dl_valid_i,
  output logic               dl_ready_o,
  input  logic [PROM_AW+1:0] dl_addr_i,
  input  logic [7:0]         dl_data_i,
  input  logic [3:0]         cpu_pal_sel_i,
  input  logic               cpu_pal_we_i,
  input  logic               LVBL_i,
  output logic [3:0]         pal_sel_o,
  output logic [PROM_AW-1:0] prog_addr_o,
  output logic [3:0]         prog_data_o,
  output logic [2:0]         prog_en_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int             CNT_W = PROM_AW + 2;
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(prom_total(PROM_AW));

  state_e               state_q;
  logic [2:0]           wr_cnt_q;
  logic                 dl_ready_q;
  logic [PROM_AW-1:0]   prog_addr_q;
  logic [3:0]           prog_data_q;
  logic [2:0]           prog_en_q;

  logic [CNT_W-1:0]     count_q, count_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic                 w_accept;
  logic [1:0]           w_bank;
  logic                 w_unused_hi;

  assign w_accept    = dl_valid_i & dl_ready_q;
  assign w_bank      = dl_addr_i[PROM_AW+1:PROM_AW];
  assign w_unused_hi = ^dl_data_i[7:4];

  // Write sequencer: latch on accept, hold prog_en for WR_CYC cycles, one idle
  // HOLD cycle, then re-open dl_ready; invalid-bank bytes skip the write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_cnt_q    <= 3'd0;
      dl_ready_q  <= 1'b0;
      prog_addr_q <= '0;
      prog_data_q <= 4'd0;
      prog_en_q   <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            prog_addr_q <= dl_addr_i[PROM_AW-1:0];
            prog_data_q <= dl_data_i[3:0];
            dl_ready_q  <= 1'b0;
            if (w_bank == BANK_INV) begin
              state_q   <= HOLD;
              prog_en_q <= 3'b000;
            end else begin
              state_q   <= WRITE;
              prog_en_q <= bank_onehot(w_bank);
              wr_cnt_q  <= 3'(WR_CYC - 1);
            end
          end else begin
            dl_ready_q <= 1'b1;
          end
        end
        WRITE: begin
          if (wr_cnt_q == 3'd0) begin
            state_q   <= HOLD;
            prog_en_q <= 3'b000;
          end else begin
            wr_cnt_q <= wr_cnt_q - 3'd1;
          end
        end
        HOLD: begin
          state_q    <= IDLE;
          dl_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          dl_ready_q <= 1'b0;
          prog_en_q  <= 3'b000;
        end
      endcase
    end
  end

  // Download bookkeeping: dl_start clears first so a coincident byte still
  // counts; done is raised once the final counted write has left HOLD
  always_comb begin
    logic [CNT_W-1:0] count_base;
    logic             done_base;
    logic             busy_base;
    logic             err_base;

    count_base = dl_start_i ? '0   : count_q;
    done_base  = dl_start_i ? 1'b0 : done_q;
    busy_base  = dl_start_i ? 1'b0 : busy_q;
    err_base   = dl_start_i ? 1'b0 : err_q;

    count_d = count_base;
    err_d   = err_base;
    if (w_accept) begin
      if (w_bank == BANK_INV) err_d = 1'b1;
      else if (count_base != TOTAL) count_d = count_base + CNT_W'(1);
    end

    done_d = done_base | ((state_q == HOLD) && (count_base == TOTAL));
    // Any byte accepted while a download is incomplete marks it in progress
    busy_d = (busy_base | (w_accept & ~done_base)) & ~done_d;
  end

  // Register the bookkeeping state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  jtkicker_pal_latch #(
    .SYNC_PAL (SYNC_PAL)
  ) u_latch (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_pal_sel_i (cpu_pal_sel_i),
    .cpu_pal_we_i  (cpu_pal_we_i),
    .LVBL_i        (LVBL_i),
    .pal_sel_o     (pal_sel_o)
  );

  assign dl_ready_o  = dl_ready_q;
  assign prog_addr_o = prog_addr_q;
  assign prog_data_o = prog_data_q;
  assign prog_en_o   = prog_en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_jtkicker_pal_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtkicker_pal_loader
// Description : Self-checking bench for the palette PROM loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtkicker_pal_loader;

  localparam int WR_CYC  = 2;
  localparam int PROM_AW = 8;
  localparam int TOTAL   = 3 * 256;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dl_start, dl_valid, dl_ready;
  logic [9:0] dl_addr;
  logic [7:0] dl_data;
  logic [3:0] cpu_pal_sel;
  logic       cpu_pal_we;
  logic       LVBL;
  logic [3:0] pal_sel;
  logic [7:0] prog_addr;
  logic [3:0] prog_data;
  logic [2:0] prog_en;
  logic       busy, done, err;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model of the download state
  int   m_count;
  bit   m_done, m_busy, m_err;
  logic [3:0] ref_mem [0:2][0:255];
  // PROM contents as written by the DUT
  logic [3:0] bmem    [0:2][0:255];

  always #5 clk = ~clk;

  jtkicker_pal_loader #(
    .WR_CYC   (WR_CYC),
    .PROM_AW  (PROM_AW),
    .SYNC_PAL (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dl_start_i    (dl_start),
    .dl_valid_i    (dl_valid),
    .dl_ready_o    (dl_ready),
    .dl_addr_i     (dl_addr),
    .dl_data_i     (dl_data),
    .cpu_pal_sel_i (cpu_pal_sel),
    .cpu_pal_we_i  (cpu_pal_we),
    .LVBL_i        (LVBL),
    .pal_sel_o     (pal_sel),
    .prog_addr_o   (prog_addr),
    .prog_data_o   (prog_data),
    .prog_en_o     (prog_en),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err)
  );

  // Model of the three colour PROMs
  always @(posedge clk) begin
    if (prog_en[0]) bmem[0][prog_addr] <= prog_data;
    if (prog_en[1]) bmem[1][prog_addr] <= prog_data;
    if (prog_en[2]) bmem[2][prog_addr] <= prog_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_count = 0;
    m_done  = 0;
    m_busy  = 0;
    m_err   = 0;
  endtask

  // Offer one byte and follow it through write, hold and ready-return
  task automatic send_byte(input logic [9:0] a, input logic [7:0] d,
                           input bit start, input bit mid_start, input bit keep_valid);
    logic [1:0] bank;
    int waited;
    bank   = a[9:8];
    waited = 0;
    while (dl_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_before_send", dl_ready, 1);
    dl_addr  = a;
    dl_data  = d;
    dl_valid = 1'b1;
    dl_start = start;
    if (start) model_clear();
    if (bank == 2'd3) m_err = 1;
    else begin
      if (m_count < TOTAL) m_count++;
      ref_mem[bank][a[7:0]] = d[3:0];
    end
    if (!m_done) m_busy = 1;
    @(negedge clk);
    dl_start = 1'b0;
    if (!keep_valid) dl_valid = 1'b0;
    chk("ready_low", dl_ready, 0);
    chk("err_accept", err, m_err);
    chk("busy_accept", busy, m_busy);
    chk("done_accept", done, m_done);
    if (bank == 2'd3) begin
      chk("inv_no_en", prog_en, 0);
      @(negedge clk);
    end else begin
      for (int k = 1; k <= WR_CYC; k++) begin
        chk("write_en", prog_en, 3'b001 << bank);
        chk("write_addr", prog_addr, a[7:0]);
        chk("write_data", prog_data, d[3:0]);
        if (k == 1 && mid_start) begin
          dl_start = 1'b1;
          model_clear();
        end
        @(negedge clk);
        dl_start = 1'b0;
      end
      chk("hold_en", prog_en, 0);
      chk("hold_addr", prog_addr, a[7:0]);
      chk("hold_data", prog_data, d[3:0]);
      chk("hold_ready", dl_ready, 0);
      if (mid_start) begin
        chk("restart_done", done, 0);
        chk("restart_busy", busy, 0);
        chk("restart_err", err, 0);
      end
      @(negedge clk);
    end
    if (m_count == TOTAL) begin
      m_done = 1;
      m_busy = 0;
    end
    chk("ready_back", dl_ready, 1);
    chk("done_end", done, m_done);
    chk("busy_end", busy, m_busy);
    chk("err_end", err, m_err);
  endtask

  initial begin
    logic [3:0] m_shadow, m_pal, v1, v2;

    rst_n       = 1'b0;
    dl_start    = 1'b0;
    dl_valid    = 1'b0;
    dl_addr     = '0;
    dl_data     = '0;
    cpu_pal_sel = '0;
    cpu_pal_we  = 1'b0;
    LVBL        = 1'b1;
    model_clear();
    m_shadow = 4'd0;
    m_pal    = 4'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", dl_ready, 0);
    chk("rst_en", prog_en, 0);
    chk("rst_addr", prog_addr, 0);
    chk("rst_data", prog_data, 0);
    chk("rst_flags", {busy, done, err}, 0);
    chk("rst_pal", pal_sel, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", dl_ready, 0);
    @(negedge clk);
    chk("ready_after_release", dl_ready, 1);

    // Single green byte
    send_byte(10'h105, 8'hA7, 0, 0, 0);

    // dl_start with accept, then restart mid-WRITE, then a full bank-sequential
    // stream with valid held high and stray bank-3 bytes mixed in
    send_byte(10'h000, 8'($urandom), 1, 1, 1);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 256; i++) begin
        if ((b * 256 + i) == 100 || $urandom_range(0, 63) == 0)
          send_byte({2'b11, 8'($urandom)}, 8'($urandom), 0, 0, 1);
        send_byte({2'(b), 8'(i)}, 8'($urandom), 0, 0, 1);
      end
    end
    dl_valid = 1'b0;
    chk("stream_done", done, 1);
    chk("stream_busy", busy, 0);
    chk("stream_err", err, 1);

    // Bytes after completion still write but leave done/busy alone
    for (int j = 0; j < 6; j++)
      send_byte({2'($urandom_range(0, 2)), 8'($urandom)}, 8'($urandom), 0, 0, 0);

    // PROM readback
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 256; i++)
        chk("readback", bmem[b][i], ref_mem[b][i]);

    // Standalone dl_start clears the sticky error and completion
    @(negedge clk);
    dl_start = 1'b1;
    model_clear();
    @(negedge clk);
    dl_start = 1'b0;
    chk("start_err", err, 0);
    chk("start_done", done, 0);
    chk("start_busy", busy, 0);
    send_byte({2'b11, 8'($urandom)}, 8'($urandom), 0, 0, 0);

    // Palette: transfer on LVBL fall, write on the edge cycle deferred a frame
    v1 = 4'($urandom_range(1, 15));
    v2 = v1 ^ 4'($urandom_range(1, 15));
    cpu_pal_sel = v1;
    cpu_pal_we  = 1'b1;
    m_shadow    = v1;
    @(negedge clk);
    cpu_pal_we = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("pal_wait_vbl", pal_sel, m_pal);
      @(negedge clk);
    end
    LVBL        = 1'b0;
    cpu_pal_sel = v2;
    cpu_pal_we  = 1'b1;
    chk("pal_before_edge", pal_sel, m_pal);
    m_pal    = m_shadow;
    m_shadow = v2;
    @(negedge clk);
    cpu_pal_we = 1'b0;
    chk("pal_first_frame", pal_sel, m_pal);
    @(negedge clk);
    LVBL = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("pal_deferred", pal_sel, m_pal);
    end
    LVBL  = 1'b0;
    m_pal = m_shadow;
    @(negedge clk);
    chk("pal_second_frame", pal_sel, m_pal);
    LVBL = 1'b1;

    // Reset pulsed during WRITE
    @(negedge clk);
    dl_addr  = 10'h2A5;
    dl_data  = 8'h3C;
    dl_valid = 1'b1;
    @(negedge clk);
    dl_valid = 1'b0;
    chk("pre_reset_en", prog_en, 3'b100);
    rst_n = 1'b0;
    #1;
    chk("reset_en", prog_en, 0);
    chk("reset_ready", dl_ready, 0);
    chk("reset_pal", pal_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_ready", dl_ready, 0);
    @(negedge clk);
    chk("release_ready_edge", dl_ready, 1);
    chk("release_en", prog_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Absolute time limit
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout observed=running expected=finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
